// File: rtl/alarm_controller.sv
// alarm_controller: stores a user-set HH:MM alarm (24-hour BCD), compares it
// against the live time digits and runs the IDLE/RINGING/SNOOZE state machine
// that drives the buzzer and the ringing/snoozing status flags.
// Optional feature macro: ALARM_BEEP_EN (1 s on / 1 s off buzzer while ringing).
module alarm_controller #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [3:0] t_sec_u,
    input  logic [2:0] t_sec_t,
    input  logic [3:0] t_min_u,
    input  logic [2:0] t_min_t,
    input  logic [3:0] t_hr_u,
    input  logic [1:0] t_hr_t,
    input  logic       alarm_en,
    input  logic       set_mode,
    input  logic       a_up_min,
    input  logic       a_down_min,
    input  logic       a_up_hour,
    input  logic       a_down_hour,
    input  logic       stop,
    input  logic       snooze,
    output logic [3:0] a_min_u,
    output logic [2:0] a_min_t,
    output logic [3:0] a_hr_u,
    output logic [1:0] a_hr_t,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    localparam int unsigned CNT_W = 9;
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SECS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_e;

    // Alarm time registers
    logic [3:0] a_min_u_q, a_min_u_d;
    logic [2:0] a_min_t_q, a_min_t_d;
    logic [3:0] a_hr_u_q,  a_hr_u_d;
    logic [1:0] a_hr_t_q,  a_hr_t_d;

    // FSM, counters and registered outputs
    state_e           state_q, state_d;
    logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
    logic             match_q;
    logic             ringing_q, ringing_d;
    logic             snoozing_q, snoozing_d;
    logic             buzzer_q, buzzer_d;
    logic             match_c;
    logic             trigger_c;

`ifdef ALARM_BEEP_EN
    logic             beep_q, beep_d;
`endif

    // Alarm edit logic: BCD wrap per field, no minute-to-hour carry
    always_comb begin
        a_min_u_d = a_min_u_q;
        a_min_t_d = a_min_t_q;
        a_hr_u_d  = a_hr_u_q;
        a_hr_t_d  = a_hr_t_q;
        if (set_mode) begin
            if (a_up_min && !a_down_min) begin
                if (a_min_u_q == 4'd9) begin
                    a_min_u_d = 4'd0;
                    a_min_t_d = (a_min_t_q == 3'd5) ? 3'd0 : a_min_t_q + 3'd1;
                end else begin
                    a_min_u_d = a_min_u_q + 4'd1;
                end
            end else if (a_down_min && !a_up_min) begin
                if (a_min_u_q == 4'd0) begin
                    a_min_u_d = 4'd9;
                    a_min_t_d = (a_min_t_q == 3'd0) ? 3'd5 : a_min_t_q - 3'd1;
                end else begin
                    a_min_u_d = a_min_u_q - 4'd1;
                end
            end

            if (a_up_hour && !a_down_hour) begin
                if (a_hr_t_q == 2'd2 && a_hr_u_q == 4'd3) begin
                    a_hr_t_d = 2'd0;
                    a_hr_u_d = 4'd0;
                end else if (a_hr_u_q == 4'd9) begin
                    a_hr_u_d = 4'd0;
                    a_hr_t_d = a_hr_t_q + 2'd1;
                end else begin
                    a_hr_u_d = a_hr_u_q + 4'd1;
                end
            end else if (a_down_hour && !a_up_hour) begin
                if (a_hr_t_q == 2'd0 && a_hr_u_q == 4'd0) begin
                    a_hr_t_d = 2'd2;
                    a_hr_u_d = 4'd3;
                end else if (a_hr_u_q == 4'd0) begin
                    a_hr_u_d = 4'd9;
                    a_hr_t_d = a_hr_t_q - 2'd1;
                end else begin
                    a_hr_u_d = a_hr_u_q - 4'd1;
                end
            end
        end
    end

    // Alarm time register update
    always_ff @(posedge clk) begin
        if (reset) begin
            a_min_u_q <= 4'd0;
            a_min_t_q <= 3'd0;
            a_hr_u_q  <= 4'd0;
            a_hr_t_q  <= 2'd0;
        end else begin
            a_min_u_q <= a_min_u_d;
            a_min_t_q <= a_min_t_d;
            a_hr_u_q  <= a_hr_u_d;
            a_hr_t_q  <= a_hr_t_d;
        end
    end

    // Match at HH:MM:00; trigger on rising edge so a stop inside the matching second sticks
    always_comb begin
        match_c = alarm_en
               && (t_hr_t  == a_hr_t_q)  && (t_hr_u  == a_hr_u_q)
               && (t_min_t == a_min_t_q) && (t_min_u == a_min_u_q)
               && (t_sec_t == 3'd0)      && (t_sec_u == 4'd0);
        trigger_c = match_c && !match_q;
    end

    // Match history register
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_c;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger_c) begin
                    state_d    = ST_RINGING;
                    ring_cnt_d = '0;
                end
            end
            ST_RINGING: begin
                if (!alarm_en || stop) begin
                    state_d = ST_IDLE;
                end else if (snooze) begin
                    state_d   = ST_SNOOZE;
                    snz_cnt_d = '0;
                end else if (sec_tick) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SNOOZE: begin
                if (!alarm_en || stop) begin
                    state_d = ST_IDLE;
                end else if (sec_tick) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ringing_d  = (state_d == ST_RINGING);
        snoozing_d = (state_d == ST_SNOOZE);
`ifdef ALARM_BEEP_EN
        // Beep restarts high on each entry into RINGING, then toggles per second
        if (state_d != ST_RINGING) begin
            beep_d = 1'b0;
        end else if (state_q != ST_RINGING) begin
            beep_d = 1'b1;
        end else if (sec_tick) begin
            beep_d = !beep_q;
        end else begin
            beep_d = beep_q;
        end
        buzzer_d = ringing_d && beep_d;
`else
        buzzer_d = ringing_d;
`endif
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
            buzzer_q   <= buzzer_d;
        end
    end

`ifdef ALARM_BEEP_EN
    // Beep phase register
    always_ff @(posedge clk) begin
        if (reset) begin
            beep_q <= 1'b0;
        end else begin
            beep_q <= beep_d;
        end
    end
`endif

    assign a_min_u  = a_min_u_q;
    assign a_min_t  = a_min_t_q;
    assign a_hr_u   = a_hr_u_q;
    assign a_hr_t   = a_hr_t_q;
    assign ringing  = ringing_q;
    assign snoozing = snoozing_q;
    assign buzzer   = buzzer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: edit table plus hand-written ring/snooze sequences.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic [3:0] t_sec_u;
    logic [2:0] t_sec_t;
    logic [3:0] t_min_u;
    logic [2:0] t_min_t;
    logic [3:0] t_hr_u;
    logic [1:0] t_hr_t;
    logic       alarm_en, set_mode;
    logic       a_up_min, a_down_min, a_up_hour, a_down_hour;
    logic       stop, snooze;
    logic [3:0] a_min_u;
    logic [2:0] a_min_t;
    logic [3:0] a_hr_u;
    logic [1:0] a_hr_t;
    logic       ringing, snoozing, buzzer;

    int errors = 0;
    int checks = 0;

    alarm_controller #(.RING_SECS(60), .SNOOZE_SECS(300)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick),
        .t_sec_u(t_sec_u), .t_sec_t(t_sec_t), .t_min_u(t_min_u), .t_min_t(t_min_t),
        .t_hr_u(t_hr_u), .t_hr_t(t_hr_t),
        .alarm_en(alarm_en), .set_mode(set_mode),
        .a_up_min(a_up_min), .a_down_min(a_down_min),
        .a_up_hour(a_up_hour), .a_down_hour(a_down_hour),
        .stop(stop), .snooze(snooze),
        .a_min_u(a_min_u), .a_min_t(a_min_t), .a_hr_u(a_hr_u), .a_hr_t(a_hr_t),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sm, um, dm, uh, dh;
        int   hh, mm;
    } edit_vec_t;

    edit_vec_t vecs[17];

    function automatic logic [15:0] alarm_now();
        return 16'({a_hr_t, a_hr_u, a_min_t, a_min_u});
    endfunction

    function automatic logic [15:0] alarm_exp(input int hh, input int mm);
        return 16'({2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10)});
    endfunction

    // {ringing, snoozing, buzzer}
    function automatic logic [15:0] status_now();
        return 16'({ringing, snoozing, buzzer});
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        t_hr_t  = 2'(h / 10);
        t_hr_u  = 4'(h % 10);
        t_min_t = 3'(m / 10);
        t_min_u = 4'(m % 10);
        t_sec_t = 3'(s / 10);
        t_sec_u = 4'(s % 10);
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        cyc();
        sec_tick = 1'b0;
        cyc();
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
    endtask

    // Step 07:29:59 -> 07:30:00 for one edge, then move to 07:30:01
    task automatic fire_0730();
        set_time(7, 29, 59);
        cyc();
        set_time(7, 30, 0);
        cyc();
        set_time(7, 30, 1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 23, 59};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 23,  0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  0,  0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 23,  0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 23,  0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23,  0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 23,  0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 23,  0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 22, 59};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 22, 58};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 23, 59};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 22, 59};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 21, 59};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20, 59};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 19, 59};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20, 59};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20,  0};

        reset = 1'b1; sec_tick = 1'b0; alarm_en = 1'b0; set_mode = 1'b0;
        a_up_min = 1'b0; a_down_min = 1'b0; a_up_hour = 1'b0; a_down_hour = 1'b0;
        stop = 1'b0; snooze = 1'b0;
        set_time(12, 34, 56);
        cyc();
        cyc();
        chk("reset_status", status_now(), 16'h0);
        chk("reset_alarm", alarm_now(), alarm_exp(0, 0));
        reset = 1'b0;

        // Edit table
        for (int i = 0; i < 17; i++) begin
            set_mode = vecs[i].sm;
            a_up_min = vecs[i].um;  a_down_min = vecs[i].dm;
            a_up_hour = vecs[i].uh; a_down_hour = vecs[i].dh;
            cyc();
            set_mode = 1'b0;
            a_up_min = 1'b0; a_down_min = 1'b0; a_up_hour = 1'b0; a_down_hour = 1'b0;
            chk($sformatf("edit_vec%0d", i), alarm_now(), alarm_exp(vecs[i].hh, vecs[i].mm));
        end

        // Plain reset restores 00:00
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("reset_pulse_alarm", alarm_now(), alarm_exp(0, 0));

        // Midnight wrap matches a 00:00 alarm
        alarm_en = 1'b1;
        set_time(23, 59, 59);
        cyc();
        chk("wrap_pre", status_now(), 16'h0);
        set_time(0, 0, 0);
        cyc();
        chk("wrap_ring", status_now(), 16'h5);
        set_time(0, 0, 1);
        pulse_stop();
        chk("wrap_stop", status_now(), 16'h0);
        set_time(12, 34, 56);

        // Program 07:30 with up pulses (covers minute 09->10 carry)
        set_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_up_hour = 1'b1; cyc(); a_up_hour = 1'b0;
        end
        for (int i = 0; i < 30; i++) begin
            a_up_min = 1'b1; cyc(); a_up_min = 1'b0;
        end
        set_mode = 1'b0;
        chk("alarm_0730", alarm_now(), alarm_exp(7, 30));

        // Trigger on the :00 edge, stop holds while still 07:30:00
        set_time(7, 29, 59);
        cyc();
        chk("pre_trigger", status_now(), 16'h0);
        set_time(7, 30, 0);
        cyc();
        chk("trigger_same_edge", status_now(), 16'h5);
        pulse_stop();
        chk("stop_idle", status_now(), 16'h0);
        cyc(); cyc(); cyc();
        chk("no_retrigger", status_now(), 16'h0);

        // Timeout after 60 ticks, entry-cycle tick not counted
        set_time(7, 29, 59);
        cyc();
        set_time(7, 30, 0);
        sec_tick = 1'b1;
        cyc();
        sec_tick = 1'b0;
        set_time(7, 30, 1);
        chk("timeout_entry", status_now(), 16'h5);
        for (int i = 0; i < 59; i++) tick();
        chk("timeout_59", status_now(), 16'h5);
        tick();
        chk("timeout_60", status_now(), 16'h0);

        // Snooze then re-ring after 300 ticks, then stop during snooze
        pulse_snooze();
        chk("snooze_in_idle", status_now(), 16'h0);
        fire_0730();
        chk("snz_ring", status_now(), 16'h5);
        pulse_snooze();
        chk("snz_enter", status_now(), 16'h2);
        for (int i = 0; i < 299; i++) tick();
        chk("snz_299", status_now(), 16'h2);
        tick();
        chk("snz_rering", status_now(), 16'h5);
        pulse_snooze();
        chk("snz_again", status_now(), 16'h2);
        pulse_snooze();
        chk("snooze_in_snooze", status_now(), 16'h2);
        pulse_stop();
        chk("snz_stop", status_now(), 16'h0);

        // Priority: stop beats snooze; alarm_en low clears snooze
        fire_0730();
        stop = 1'b1; snooze = 1'b1;
        cyc();
        stop = 1'b0; snooze = 1'b0;
        chk("stop_over_snooze", status_now(), 16'h0);
        fire_0730();
        pulse_snooze();
        chk("pri_snooze", status_now(), 16'h2);
        alarm_en = 1'b0;
        cyc();
        chk("en_low_snooze", status_now(), 16'h0);
        alarm_en = 1'b1;
        fire_0730();
        alarm_en = 1'b0;
        cyc();
        chk("en_low_ring", status_now(), 16'h0);
        alarm_en = 1'b1;

        // Edit while ringing keeps ringing; reset mid-ring clears all
        fire_0730();
        set_mode = 1'b1; a_up_min = 1'b1;
        cyc();
        set_mode = 1'b0; a_up_min = 1'b0;
        chk("edit_ring_status", status_now(), 16'h5);
        chk("edit_ring_alarm", alarm_now(), alarm_exp(7, 31));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("reset_ring_status", status_now(), 16'h0);
        chk("reset_ring_alarm", alarm_now(), alarm_exp(0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Downstream consumer of the minutes/seconds/hours time counter. Holds a user-set alarm time (HH:MM, 24-hour BCD) and compares it against the live time digits. Drives a three-state ring/snooze/idle state machine that produces the buzzer output and status flags for the display and LED stage.

## Interface

Parameters:
- RING_SECS, 60, number of sec_tick pulses the alarm rings before auto-stop (1..511)
- SNOOZE_SECS, 300, number of sec_tick pulses spent in snooze before re-ringing (1..511)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- sec_tick  in  1  one-cycle pulse per second; the same enable that advances the time counter
- t_sec_u  in  4  live seconds units (0-9)
- t_sec_t  in  3  live seconds tens (0-5)
- t_min_u  in  4  live minutes units (0-9)
- t_min_t  in  3  live minutes tens (0-5)
- t_hr_u  in  4  live hours units (0-9)
- t_hr_t  in  2  live hours tens (0-2)
- alarm_en  in  1  alarm armed (level switch)
- set_mode  in  1  alarm-edit mode (level); edit pulses are ignored when low
- a_up_min, a_down_min, a_up_hour, a_down_hour  in  1 each  one-cycle edit pulses
- stop  in  1  one-cycle pulse; silence the alarm
- snooze  in  1  one-cycle pulse; request snooze
- a_min_u  out  4  stored alarm minutes units
- a_min_t  out  3  stored alarm minutes tens
- a_hr_u  out  4  stored alarm hours units
- a_hr_t  out  2  stored alarm hours tens
- ringing  out  1  FSM in RINGING
- snoozing  out  1  FSM in SNOOZE
- buzzer  out  1  buzzer drive

## Operation

- **Alarm registers.** On reset, the alarm is 00:00. Edits are applied only when set_mode=1.
  - Minutes are a 00-59 wrap with no carry into hours: 59 up → 00, 00 down → 59.
  - Hours are a 00-23 wrap: 23 up → 00, 00 down → 23.
  - If both the up and down pulses of one field arrive together, there is no change to that field.
  - Minute and hour edits in the same cycle are both applied.
- **Match.** match is true when alarm_en=1, the live HH:MM equals the alarm HH:MM, and t_sec_t=0, t_sec_u=0.
  - match_q is match registered one cycle.
  - trigger is defined as match & ~match_q (a rising edge), so a stop issued within the matching second does not re-trigger.
- **States.** The FSM has three states: IDLE, RINGING, SNOOZE.
  - IDLE → RINGING on trigger; ring_cnt cleared.
  - RINGING → IDLE on stop, or on a sec_tick when ring_cnt = RING_SECS-1.
  - RINGING → SNOOZE on snooze (and no stop); snz_cnt cleared.
  - SNOOZE → RINGING on a sec_tick when snz_cnt = SNOOZE_SECS-1; ring_cnt cleared.
  - SNOOZE → IDLE on stop.
  - Any state → IDLE when alarm_en=0. This has the highest priority after reset.
- **Priority.** reset > alarm_en=0 > stop > snooze > timeout > trigger.
  - snooze in IDLE or SNOOZE is ignored.
  - stop in IDLE is ignored.
- **Counters.** Both counters are 9 bits and increment only on sec_tick within their own state. Both are cleared on reset.
- **Interaction with edits.** Editing the alarm while RINGING or SNOOZE does not change the state; only future matches are affected.

## Timing

- All outputs are registered.
- Reset values: alarm digits all 0; ringing=0, snoozing=0, buzzer=0; FSM=IDLE; match_q=0.
- Trigger latency: the first clock edge where the inputs show the alarm HH:MM:00 sets match. ringing and buzzer assert on that same edge.
- stop, snooze, and alarm_en-low each take effect on the next edge; outputs update at that edge.
- Alarm register edits are visible on the a_* outputs one edge after the pulse.
- Time wrap from 23:59:59 to 00:00:00 matches an alarm at 00:00 normally.
- Reset asserted mid-ring forces IDLE and buzzer=0 at the next edge; the alarm time returns to 00:00.
- Ring duration is exactly RING_SECS sec_ticks from entry. The tick in the entry cycle is not counted.

## Configuration

- Macro: ALARM_BEEP_EN.
- Defined: buzzer = ringing & beep.
  - beep is a register that toggles on each sec_tick while RINGING, giving 1 s on / 1 s off.
  - beep is set to 1 on every entry into RINGING and is 0 otherwise.
- Undefined: buzzer = ringing (continuous tone); no beep register is built.

## Test plan

- **Edit wrap:** set_mode=1 with an alarm of 23:59; a_up_min → 23:00; a_up_hour → 00:00; a_down_hour → 23:00. With set_mode=0, pulses leave the value unchanged.
- **Trigger and stop:** alarm 07:30, time stepped to 07:30:00 → ringing=1 on the same edge. Pulse stop at 07:30:00 → IDLE, with no re-trigger while the time stays at 07:30:00.
- **Auto-timeout:** RING_SECS=60 and trigger → ringing stays 1 for 60 sec_ticks, then drops to 0. With ALARM_BEEP_EN defined, buzzer alternates 1/0 each second.
- **Snooze:** snooze while ringing → snoozing=1, buzzer=0. After SNOOZE_SECS=300 ticks → ringing=1 again. Stop during snooze → IDLE.
- **Priority:** stop and snooze in the same cycle while RINGING → IDLE. alarm_en dropped during SNOOZE → IDLE next edge.
- **Reset mid-ring:** reset while RINGING → all outputs 0 and alarm 00:00 on the next edge.
